fm_sweep_wb_master: RTL and testbench
=====================================

// Module: fm_sweep_wb_master
// PURPOSE
//  Wishbone (pipelined, B4) initiator that programs the FM generator register map.
//  On i_start it writes modulation frequency (addr 1) and deviation (addr 2).
//  It then steps the carrier centre frequency (addr 0) from i_start_freq by i_step, holding each value i_dwell cycles.
//  It reads addr 0 back at the end and flags a mismatch. Sits between control logic and the FM generator slave.
// PARAMETERS
//  STEPS_W     16   width of step count / step index
//  DWELL_W     24   width of dwell counter
//  TIMEOUT     255  max cycles from stb acceptance to ack before error (>=1)
// PORTS
//  i_clk          in   1        system clock
//  i_reset_n      in   1        async active-low reset
//  i_start        in   1        1-cycle pulse; starts a sweep (ignored unless IDLE)
//  i_abort        in   1        stop sweep after any outstanding bus cycle completes
//  i_start_freq   in   32       first carrier increment
//  i_step         in   32       signed per-step increment delta (two's complement)
//  i_num_steps    in   STEPS_W  number of carrier writes (0 treated as 1)
//  i_dwell        in   DWELL_W  cycles to hold each carrier value after its ack
//  i_mod_freq     in   32       value written to addr 1
//  i_mod_dev      in   32       value written to addr 2
//  o_wb_cyc       out  1        bus cycle
//  o_wb_stb       out  1        strobe
//  o_wb_we        out  1        1=write, 0=read
//  o_wb_addr      out  2        register address
//  o_wb_data      out  32       write data
//  i_wb_ack       in   1        slave ack
//  i_wb_stall     in   1        slave stall
//  i_wb_data      in   32       read data (valid with ack)
//  o_busy         out  1        high from start acceptance until DONE/ERR exit
//  o_done         out  1        1-cycle pulse at normal completion
//  o_err          out  1        sticky: timeout or readback mismatch; cleared by next accepted i_start
//  o_step_idx     out  STEPS_W  index of carrier value currently applied
// BEHAVIOUR
//  Reset (async, i_reset_n=0): all outputs 0, state IDLE, counters 0.
//  States: IDLE -> WR_MOD -> WR_DEV -> WR_CAR -> DWELL -> (WR_CAR | RD_CAR) -> DONE -> IDLE; any -> ERR -> IDLE.
//  IDLE: i_start=1 latches all i_* config, clears o_err, sets o_busy, goes to WR_MOD next cycle.
//  Bus cycle: cyc=stb=1 with addr/data/we driven; stb drops the cycle after sampled with i_wb_stall=0.
//  Bus cycle: cyc held until i_wb_ack; exactly one outstanding transaction; addr/data stable while stb=1.
//  Ack while stb still high with stall=0 (zero-wait slave): accepted; cyc and stb drop the same edge.
//  Timeout: counter starts at stb acceptance; no ack within TIMEOUT cycles -> drop cyc, set o_err, go ERR.
//  Timeout: stall cycles do not count toward TIMEOUT.
//  WR_CAR: data = cur_freq; on ack, o_step_idx = step number (0-based), enter DWELL.
//  DWELL: counts i_dwell cycles (0 -> zero extra cycles).
//  DWELL, after last step: go RD_CAR. DWELL, otherwise: cur_freq += i_step (mod 2^32, wraps), idx+1, go WR_CAR.
//  RD_CAR: we=0, addr=0; on ack compare i_wb_data to last written cur_freq.
//  RD_CAR compare: mismatch -> o_err=1 and ERR; match -> DONE.
//  DONE: o_done=1 for one cycle, o_busy=0 next cycle, return IDLE. ERR: o_busy=0, return IDLE next cycle.
//  Abort between bus cycles: go IDLE directly (no o_done, o_err unchanged).
//  Abort during a bus cycle: complete that cycle (ack or timeout) first, then go IDLE.
//  i_start while busy: ignored. Abort and start in the same IDLE cycle: start wins.
//  Reset mid-cycle drops cyc/stb immediately (async). Slave must tolerate an abandoned cycle.
//  Ack with cyc=0 is ignored.
// TESTING
//  Zero-wait slave (ack 1 cycle after stb), start=0x444444, step=0x100, n=3, dwell=4 -> checks below.
//   Bus writes: a1,a2, then a0=0x444444, 0x444544, 0x444644, each 4 idle cycles after ack.
//   Then read a0; o_done pulse, o_err=0.
//  Slave stalls 3 cycles per request -> stb held high 4 cycles, addr/data stable; same write sequence.
//  No ack ever -> cyc drops after TIMEOUT cycles, o_err=1, o_busy=0; next start clears o_err.
//  Slave returns corrupted readback (xor 1) -> o_err=1, no o_done.
//  start=0xFFFFFF00, step=0x200, n=2 -> second carrier write 0x00000100 (wrap).
//  i_abort during DWELL of step 1 of 5 -> no further bus cycles, o_busy=0, o_done never asserted.
//  Async reset asserted mid-stb -> cyc/stb 0 same edge.

Source files
------------

// File: rtl/fm_sweep_wb_master.sv
// Wishbone B4 pipelined initiator that programs an FM generator and sweeps
// its carrier frequency, reading the final carrier back for verification.
module fm_sweep_wb_master #(
    parameter int STEPS_W = 16,
    parameter int DWELL_W = 24,
    parameter int TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [31:0]        i_start_freq,
    input  logic [31:0]        i_step,
    input  logic [STEPS_W-1:0] i_num_steps,
    input  logic [DWELL_W-1:0] i_dwell,
    input  logic [31:0]        i_mod_freq,
    input  logic [31:0]        i_mod_dev,
    output logic               o_wb_cyc,
    output logic               o_wb_stb,
    output logic               o_wb_we,
    output logic [1:0]         o_wb_addr,
    output logic [31:0]        o_wb_data,
    input  logic               i_wb_ack,
    input  logic               i_wb_stall,
    input  logic [31:0]        i_wb_data,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err,
    output logic [STEPS_W-1:0] o_step_idx
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_MOD,
        S_WR_DEV,
        S_WR_CAR,
        S_DWELL,
        S_RD_CAR,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic               cyc_q, cyc_d;
    logic               stb_q, stb_d;
    logic               we_q, we_d;
    logic [1:0]         addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               abort_q, abort_d;
    logic [STEPS_W-1:0] step_idx_q, step_idx_d;
    logic [STEPS_W-1:0] idx_q, idx_d;
    logic [STEPS_W-1:0] last_q, last_d;
    logic [31:0]        cur_freq_q, cur_freq_d;
    logic [31:0]        step_q, step_d;
    logic [31:0]        mod_dev_q, mod_dev_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [TW-1:0]      tmo_q, tmo_d;

    logic is_bus;
    logic ack_ok;
    logic tmo_hit;
    logic dwell_exit;
    logic abort_now;

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        addr_d      = addr_q;
        data_d      = data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        step_idx_d  = step_idx_q;
        idx_d       = idx_q;
        last_d      = last_q;
        cur_freq_d  = cur_freq_q;
        step_d      = step_q;
        mod_dev_d   = mod_dev_q;
        dwell_d     = dwell_q;
        dwell_cnt_d = dwell_cnt_q;
        tmo_d       = tmo_q;
        ack_ok      = 1'b0;
        tmo_hit     = 1'b0;
        dwell_exit  = 1'b0;
        abort_now   = abort_q | i_abort;
        abort_d     = (state_q != S_IDLE) && abort_now;

        is_bus = (state_q == S_WR_MOD) || (state_q == S_WR_DEV) ||
                 (state_q == S_WR_CAR) || (state_q == S_RD_CAR);

        // Timeout runs only once the slave has taken the request.
        if (is_bus) begin
            if (stb_q) begin
                if (!i_wb_stall) begin
                    stb_d  = 1'b0;
                    tmo_d  = '0;
                    ack_ok = i_wb_ack;
                end
            end else if (i_wb_ack) begin
                ack_ok = 1'b1;
            end else if (tmo_q == TMO_LAST) begin
                tmo_hit = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
            if (ack_ok) begin
                cyc_d = 1'b0;
                stb_d = 1'b0;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    err_d       = 1'b0;
                    busy_d      = 1'b1;
                    step_d      = i_step;
                    mod_dev_d   = i_mod_dev;
                    dwell_d     = i_dwell;
                    cur_freq_d  = i_start_freq;
                    idx_d       = '0;
                    step_idx_d  = '0;
                    dwell_cnt_d = '0;
                    tmo_d       = '0;
                    last_d      = (i_num_steps == '0) ? '0
                                : i_num_steps - STEPS_W'(1);
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    we_d        = 1'b1;
                    addr_d      = 2'd1;
                    data_d      = i_mod_freq;
                    state_d     = S_WR_MOD;
                end
            end
            S_WR_MOD: begin
                if (ack_ok) begin
                    if (abort_now) begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        we_d    = 1'b1;
                        addr_d  = 2'd2;
                        data_d  = mod_dev_q;
                        state_d = S_WR_DEV;
                    end
                end
            end
            S_WR_DEV: begin
                if (ack_ok) begin
                    if (abort_now) begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        we_d    = 1'b1;
                        addr_d  = 2'd0;
                        data_d  = cur_freq_q;
                        state_d = S_WR_CAR;
                    end
                end
            end
            S_WR_CAR: begin
                if (ack_ok) begin
                    step_idx_d  = idx_q;
                    dwell_cnt_d = '0;
                    if (dwell_q == '0) begin
                        dwell_exit = 1'b1;
                    end else begin
                        state_d = S_DWELL;
                    end
                end
            end
            S_DWELL: begin
                if (abort_now) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (dwell_cnt_q == dwell_q - DWELL_W'(1)) begin
                    dwell_exit = 1'b1;
                end else begin
                    dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                end
            end
            S_RD_CAR: begin
                if (ack_ok) begin
                    if (abort_now) begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else if (i_wb_data != cur_freq_q) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_ERR: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        if (dwell_exit) begin
            if (abort_now) begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end else if (idx_q == last_q) begin
                cyc_d   = 1'b1;
                stb_d   = 1'b1;
                we_d    = 1'b0;
                addr_d  = 2'd0;
                data_d  = '0;
                state_d = S_RD_CAR;
            end else begin
                cur_freq_d = cur_freq_q + step_q;
                idx_d      = idx_q + STEPS_W'(1);
                cyc_d      = 1'b1;
                stb_d      = 1'b1;
                we_d       = 1'b1;
                addr_d     = 2'd0;
                data_d     = cur_freq_q + step_q;
                state_d    = S_WR_CAR;
            end
        end

        if (tmo_hit) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            err_d   = 1'b1;
            state_d = S_ERR;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= S_IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            abort_q     <= 1'b0;
            step_idx_q  <= '0;
            idx_q       <= '0;
            last_q      <= '0;
            cur_freq_q  <= '0;
            step_q      <= '0;
            mod_dev_q   <= '0;
            dwell_q     <= '0;
            dwell_cnt_q <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            abort_q     <= abort_d;
            step_idx_q  <= step_idx_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            cur_freq_q  <= cur_freq_d;
            step_q      <= step_d;
            mod_dev_q   <= mod_dev_d;
            dwell_q     <= dwell_d;
            dwell_cnt_q <= dwell_cnt_d;
            tmo_q       <= tmo_d;
        end
    end

    assign o_wb_cyc   = cyc_q;
    assign o_wb_stb   = stb_q;
    assign o_wb_we    = we_q;
    assign o_wb_addr  = addr_q;
    assign o_wb_data  = data_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_err      = err_q;
    assign o_step_idx = step_idx_q;

endmodule

// File: tb/tb_fm_sweep_wb_master.sv
// Scoreboard bench for fm_sweep_wb_master: a model pushes the expected
// bus requests, a monitor pops and compares each accepted request.
module tb_fm_sweep_wb_master;

    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic [31:0] i_start_freq = '0;
    logic [31:0] i_step = '0;
    logic [15:0] i_num_steps = '0;
    logic [23:0] i_dwell = '0;
    logic [31:0] i_mod_freq = '0;
    logic [31:0] i_mod_dev = '0;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [1:0]  o_wb_addr;
    logic [31:0] o_wb_data;
    logic        i_wb_ack = 1'b0;
    logic        i_wb_stall = 1'b0;
    logic [31:0] i_wb_data = '0;
    logic        o_busy, o_done, o_err;
    logic [15:0] o_step_idx;

    always #5 clk = ~clk;

    fm_sweep_wb_master #(
        .STEPS_W(16),
        .DWELL_W(24),
        .TIMEOUT(TMO)
    ) dut (
        .i_clk(clk),
        .i_reset_n(rst_n),
        .i_start(i_start),
        .i_abort(i_abort),
        .i_start_freq(i_start_freq),
        .i_step(i_step),
        .i_num_steps(i_num_steps),
        .i_dwell(i_dwell),
        .i_mod_freq(i_mod_freq),
        .i_mod_dev(i_mod_dev),
        .o_wb_cyc(o_wb_cyc),
        .o_wb_stb(o_wb_stb),
        .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr),
        .o_wb_data(o_wb_data),
        .i_wb_ack(i_wb_ack),
        .i_wb_stall(i_wb_stall),
        .i_wb_data(i_wb_data),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_err(o_err),
        .o_step_idx(o_step_idx)
    );

    typedef struct packed {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] data;
    } req_t;

    req_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          req_cnt = 0;
    int          cyc_n = 0;
    int          stall_n = 0;
    bit          noack = 0;
    bit          corrupt = 0;
    int          exp_dwell = 0;
    bit          car_ack_v = 0;
    int          car_ack_at = 0;
    logic [31:0] regs [4];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(string nm);
        total++;
        bad++;
        $display("FAIL %s: got timeout want event", nm);
    endtask

    task automatic push_model(logic [31:0] st, logic [31:0] sp,
                              logic [15:0] n, logic [31:0] mf,
                              logic [31:0] md);
        int nn;
        nn = (n == 0) ? 1 : int'(n);
        exp_q.push_back(req_t'({1'b1, 2'd1, mf}));
        exp_q.push_back(req_t'({1'b1, 2'd2, md}));
        for (int i = 0; i < nn; i++)
            exp_q.push_back(req_t'({1'b1, 2'd0, st + 32'(i) * sp}));
        exp_q.push_back(req_t'({1'b0, 2'd0, 32'd0}));
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 i_start = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
    endtask

    task automatic set_cfg(logic [31:0] st, logic [31:0] sp,
                           logic [15:0] n, logic [23:0] dw);
        i_start_freq = st;
        i_step       = sp;
        i_num_steps  = n;
        i_dwell      = dw;
        i_mod_freq   = $urandom;
        i_mod_dev    = $urandom;
    endtask

    // Slave: stalls stall_n cycles per request, acks one cycle after accept.
    initial begin : slave
        bit   acc;
        req_t r;
        int   scnt;
        scnt = 0;
        forever begin
            @(negedge clk);
            acc = o_wb_cyc && o_wb_stb && !i_wb_stall;
            r   = {o_wb_we, o_wb_addr, o_wb_data};
            @(posedge clk);
            #1;
            i_wb_ack = 1'b0;
            if (acc && !noack) begin
                i_wb_ack = 1'b1;
                if (r.we) regs[r.addr] = r.data;
                else i_wb_data = regs[0] ^ {31'd0, corrupt};
            end
            if (!o_wb_stb) begin
                i_wb_stall = 1'b0;
                scnt = 0;
            end else if (scnt < stall_n) begin
                i_wb_stall = 1'b1;
                scnt++;
            end else begin
                i_wb_stall = 1'b0;
            end
        end
    end

    initial begin : monitor
        req_t r, e, prev;
        bit   prev_hold;
        bit   last_car;
        int   stb_len;
        prev_hold = 0;
        last_car  = 0;
        stb_len   = 0;
        forever begin
            @(negedge clk);
            cyc_n++;
            if (!rst_n) begin
                prev_hold = 0;
                last_car  = 0;
                stb_len   = 0;
                car_ack_v = 0;
            end else begin
                if (o_done) done_cnt++;
                r = {o_wb_we, o_wb_addr, o_wb_data};
                if (o_wb_cyc && i_wb_ack) begin
                    if (last_car) begin
                        car_ack_v  = 1;
                        car_ack_at = cyc_n;
                    end
                    last_car = 0;
                end
                if (o_wb_stb) begin
                    if (stb_len == 0 && car_ack_v) begin
                        chk("dwell_gap", 32'(cyc_n - car_ack_at - 1),
                            32'(exp_dwell));
                        car_ack_v = 0;
                    end
                    if (prev_hold) begin
                        chk("hold_kind", {29'd0, r.we, r.addr},
                            {29'd0, prev.we, prev.addr});
                        chk("hold_data", r.data, prev.data);
                    end
                    stb_len++;
                    if (!i_wb_stall) begin
                        req_cnt++;
                        chk("stb_len", 32'(stb_len), 32'(stall_n + 1));
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_req: got addr %0d want none",
                                     r.addr);
                        end else begin
                            e = exp_q.pop_front();
                            chk("req_kind", {29'd0, r.we, r.addr},
                                {29'd0, e.we, e.addr});
                            if (e.we) chk("req_data", r.data, e.data);
                        end
                        last_car  = r.we && (r.addr == 2'd0);
                        stb_len   = 0;
                        prev_hold = 0;
                    end else begin
                        prev      = r;
                        prev_hold = 1;
                    end
                end else begin
                    stb_len   = 0;
                    prev_hold = 0;
                end
            end
        end
    end

    task automatic run_sweep(string tag, logic [31:0] st, logic [31:0] sp,
                             logic [15:0] n, logic [23:0] dw, int stl,
                             bit bad_rd);
        int nn;
        int k;
        nn        = (n == 0) ? 1 : int'(n);
        stall_n   = stl;
        corrupt   = bad_rd;
        exp_dwell = int'(dw);
        car_ack_v = 0;
        done_cnt  = 0;
        set_cfg(st, sp, n, dw);
        push_model(st, sp, n, i_mod_freq, i_mod_dev);
        pulse_start();
        chk({tag, "_busy_start"}, {31'd0, o_busy}, 32'd1);
        chk({tag, "_err_clr"}, {31'd0, o_err}, 32'd0);
        k = 0;
        while (o_busy && k < 20000) begin
            @(negedge clk);
            k++;
        end
        if (o_busy) fail_now({tag, "_end"});
        repeat (2) @(negedge clk);
        chk({tag, "_done"}, 32'(done_cnt), bad_rd ? 32'd0 : 32'd1);
        chk({tag, "_err"}, {31'd0, o_err}, {31'd0, bad_rd});
        chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_idx"}, {16'd0, o_step_idx}, 32'(nn - 1));
        exp_q.delete();
        corrupt = 0;
    endtask

    initial begin : main
        int k;
        int rc;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc", {31'd0, o_wb_cyc}, 32'd0);
        chk("rst_stb", {31'd0, o_wb_stb}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_err", {31'd0, o_err}, 32'd0);
        chk("rst_idx", {16'd0, o_step_idx}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_sweep("basic", 32'h0044_4444, 32'h100, 16'd3, 24'd4, 0, 0);
        run_sweep("stall", 32'h0044_4444, 32'h100, 16'd3, 24'd4, 3, 0);

        noack   = 1;
        stall_n = 0;
        set_cfg(32'h1000, 32'h10, 16'd2, 24'd1);
        exp_q.push_back(req_t'({1'b1, 2'd1, i_mod_freq}));
        pulse_start();
        k = 0;
        while (!(o_wb_cyc && !o_wb_stb) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) fail_now("noack_accept");
        k = 0;
        while (o_wb_cyc && k < 1000) begin
            k++;
            @(negedge clk);
        end
        chk("tmo_cycles", 32'(k), 32'(TMO));
        repeat (3) @(negedge clk);
        chk("tmo_err", {31'd0, o_err}, 32'd1);
        chk("tmo_busy", {31'd0, o_busy}, 32'd0);
        noack = 0;
        exp_q.delete();

        run_sweep("after_tmo", 32'h0012_3400, 32'h1, 16'd2, 24'd2, 1, 0);
        run_sweep("badrd", 32'h0044_4444, 32'h100, 16'd3, 24'd1, 0, 1);
        run_sweep("wrap", 32'hFFFF_FF00, 32'h200, 16'd2, 24'd1, 0, 0);
        run_sweep("zero_n", 32'h0000_ABCD, 32'h7, 16'd0, 24'd0, 0, 0);
        run_sweep("neg", 32'h0000_0010, 32'hFFFF_FFF0, 16'd3, 24'd0, 2, 0);

        stall_n   = 0;
        exp_dwell = 8;
        car_ack_v = 0;
        done_cnt  = 0;
        set_cfg(32'h0050_0000, 32'h40, 16'd5, 24'd8);
        push_model(i_start_freq, i_step, i_num_steps, i_mod_freq, i_mod_dev);
        pulse_start();
        k = 0;
        while (!(o_step_idx == 16'd1 && !o_wb_cyc) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) fail_now("abort_reach");
        @(posedge clk);
        #1 i_abort = 1'b1;
        @(posedge clk);
        #1 i_abort = 1'b0;
        exp_q.delete();
        rc = req_cnt;
        repeat (40) @(negedge clk);
        chk("abort_reqs", 32'(req_cnt), 32'(rc));
        chk("abort_busy", {31'd0, o_busy}, 32'd0);
        chk("abort_done", 32'(done_cnt), 32'd0);
        chk("abort_err", {31'd0, o_err}, 32'd0);

        stall_n = 3;
        set_cfg(32'h0000_1111, 32'h1, 16'd2, 24'd1);
        push_model(i_start_freq, i_step, i_num_steps, i_mod_freq, i_mod_dev);
        pulse_start();
        k = 0;
        while (!o_wb_stb && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) fail_now("rst_reach");
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cyc", {31'd0, o_wb_cyc}, 32'd0);
        chk("arst_stb", {31'd0, o_wb_stb}, 32'd0);
        chk("arst_busy", {31'd0, o_busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clk);

        for (int t = 0; t < 8; t++) begin
            run_sweep("rnd", $urandom, $urandom,
                      16'($urandom_range(0, 4)),
                      24'($urandom_range(0, 5)),
                      int'($urandom_range(0, 2)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
